// File: rtl/imem_boot_loader.sv
// Boot loader: turns a length-prefixed byte stream into instruction-memory writes,
// holding the core in reset until the image is loaded and the hold time has elapsed.
module imem_boot_loader #(
  parameter int XLEN       = 32,
  parameter int IMEM_WORDS = 1024,
  parameter int RST_HOLD   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx_valid,
  input  logic [7:0]      rx_data,
  output logic            rx_ready,
  input  logic            restart,
  output logic            dbg_wr_en,
  output logic [XLEN-1:0] dbg_addr,
  output logic [XLEN-1:0] dbg_instr,
  output logic            core_rst,
  output logic            load_done,
  output logic            load_err
);

  // state   | meaning
  // HDR0    | waiting for word count low byte
  // HDR1    | waiting for word count high byte
  // DATA    | collecting the 4 bytes of one instruction
  // SETUP   | address/data settle before the strobe
  // WRITE   | imem write strobe (suppressed beyond capacity)
  // RELEASE | counting core reset hold time
  // DONE    | core running; waiting for restart
  typedef enum logic [2:0] {
    HDR0    = 3'd0,
    HDR1    = 3'd1,
    DATA    = 3'd2,
    SETUP   = 3'd3,
    WRITE   = 3'd4,
    RELEASE = 3'd5,
    DONE    = 3'd6
  } state_t;

  localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD + 1) : 1;

  state_t        state, state_nxt;
  logic [7:0]    cnt_lo;
  logic [15:0]   remaining;
  logic [31:0]   word_idx;
  logic [1:0]    byte_idx;
  logic [23:0]   shift_buf;
  logic [HW-1:0] hold_cnt;

  logic xfer;
  logic in_range;
  logic hdr_zero;
  logic ready_nxt;
  logic wr_en_nxt;

  assign xfer     = rx_valid & rx_ready;
  assign in_range = word_idx < 32'(IMEM_WORDS);
  assign hdr_zero = ({rx_data, cnt_lo} == 16'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= HDR0;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      HDR0:    if (xfer) state_nxt = HDR1;
      HDR1:    if (xfer) state_nxt = hdr_zero ? RELEASE : DATA;
      DATA:    if (xfer && byte_idx == 2'd3) state_nxt = SETUP;
      SETUP:   state_nxt = WRITE;
      WRITE:   state_nxt = (remaining == 16'd1) ? RELEASE : DATA;
      RELEASE: if (hold_cnt == '0) state_nxt = DONE;
      DONE:    if (restart) state_nxt = HDR0;
      default: state_nxt = HDR0;
    endcase
    ready_nxt = (state_nxt == HDR0) || (state_nxt == HDR1) || (state_nxt == DATA);
    wr_en_nxt = (state_nxt == WRITE) && in_range;
  end

  // rx_ready and dbg_wr_en are registered copies of the next-state decode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_ready  <= 1'b1;
      dbg_wr_en <= 1'b0;
      dbg_addr  <= '0;
      dbg_instr <= '0;
      core_rst  <= 1'b1;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      cnt_lo    <= '0;
      remaining <= '0;
      word_idx  <= '0;
      byte_idx  <= '0;
      shift_buf <= '0;
      hold_cnt  <= '0;
    end else begin
      rx_ready  <= ready_nxt;
      dbg_wr_en <= wr_en_nxt;
      case (state)
        HDR0: if (xfer) cnt_lo <= rx_data;
        HDR1: begin
          if (xfer) begin
            remaining <= {rx_data, cnt_lo};
            if (hdr_zero) hold_cnt <= HW'(RST_HOLD - 1);
          end
        end
        DATA: begin
          if (xfer) begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: shift_buf[7:0]   <= rx_data;
              2'd1: shift_buf[15:8]  <= rx_data;
              2'd2: shift_buf[23:16] <= rx_data;
              default: dbg_instr     <= XLEN'({rx_data, shift_buf});
            endcase
          end
        end
        WRITE: begin
          dbg_addr  <= dbg_addr + XLEN'(4);
          remaining <= remaining - 16'd1;
          word_idx  <= word_idx + 32'd1;
          if (!in_range) load_err <= 1'b1;
          if (remaining == 16'd1) hold_cnt <= HW'(RST_HOLD - 1);
        end
        RELEASE: begin
          if (hold_cnt == '0) begin
            core_rst  <= 1'b0;
            load_done <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt - HW'(1);
          end
        end
        DONE: begin
          if (restart) begin
            core_rst  <= 1'b1;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            dbg_addr  <= '0;
            word_idx  <= '0;
            byte_idx  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: streams byte images with random gaps and compares the
// observed writes, handshake timing and reset release against a stream-level model.
module tb_imem_boot_loader;

  localparam int XLEN  = 32;
  localparam int IMEMW = 8;
  localparam int HOLD  = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            rx_valid = 1'b0;
  logic [7:0]      rx_data = '0;
  logic            rx_ready;
  logic            restart = 1'b0;
  logic            dbg_wr_en;
  logic [XLEN-1:0] dbg_addr;
  logic [XLEN-1:0] dbg_instr;
  logic            core_rst;
  logic            load_done;
  logic            load_err;

  imem_boot_loader #(.XLEN(XLEN), .IMEM_WORDS(IMEMW), .RST_HOLD(HOLD)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .restart(restart), .dbg_wr_en(dbg_wr_en), .dbg_addr(dbg_addr), .dbg_instr(dbg_instr),
    .core_rst(core_rst), .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // observation log, filled at the falling edge
  int          cyc = 0;
  int          acc_cyc_q[$];
  int          wr_cyc_q[$];
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_instr_q[$];
  int          fall_cyc = -1;
  logic        prev_core_rst = 1'b1;

  always @(negedge clk) begin
    cyc++;
    if (rx_valid && rx_ready) acc_cyc_q.push_back(cyc);
    if (dbg_wr_en) begin
      wr_cyc_q.push_back(cyc);
      wr_addr_q.push_back(dbg_addr);
      wr_instr_q.push_back(dbg_instr);
    end
    if (prev_core_rst && !core_rst) fall_cyc = cyc;
    prev_core_rst = core_rst;
  end

  logic [7:0] stream_q[$];

  task automatic clear_log();
    acc_cyc_q.delete();
    wr_cyc_q.delete();
    wr_addr_q.delete();
    wr_instr_q.delete();
    fall_cyc = -1;
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) stream_q.push_back(w[8*b +: 8]);
  endtask

  task automatic new_stream(input int n);
    stream_q.delete();
    stream_q.push_back(8'(n));
    stream_q.push_back(8'(n >> 8));
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit done = 1'b0;
    rx_data = b;
    for (int k = 0; k < 200 && !done; k++) begin
      rx_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      if (rx_valid && rx_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0;
    if (!done) check("send_timeout", 0, 1);
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(posedge clk);
    #1;
    restart = 1'b0;
    check("rs_core_rst", core_rst, 1);
    check("rs_load_done", load_done, 0);
    check("rs_load_err", load_err, 0);
    check("rs_addr", dbg_addr, 0);
    check("rs_rx_ready", rx_ready, 1);
  endtask

  // Send stream_q, then compare against what the stream rules imply.
  task automatic run_stream(input bit gaps, input bit stray);
    int n, ne, last;
    bit seen;
    logic [31:0] w;
    clear_log();
    for (int i = 0; i < stream_q.size(); i++) begin
      send_byte(stream_q[i], gaps);
      if (stray && i == 3) begin
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
      end
    end
    seen = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clk);
      if (load_done) seen = 1'b1;
    end
    @(posedge clk);
    #1;
    n  = int'(stream_q[0]) + 256 * int'(stream_q[1]);
    ne = (n < IMEMW) ? n : IMEMW;
    check("load_done", load_done, 1);
    check("core_rst_rel", core_rst, 0);
    check("load_err", load_err, (n > IMEMW) ? 1 : 0);
    check("rx_ready_done", rx_ready, 0);
    check("bytes_accepted", acc_cyc_q.size(), stream_q.size());
    check("write_count", wr_addr_q.size(), ne);
    for (int i = 0; i < ne && i < wr_addr_q.size(); i++) begin
      for (int b = 0; b < 4; b++) w[8*b +: 8] = stream_q[2 + 4*i + b];
      check("wr_addr", wr_addr_q[i], 4 * i);
      check("wr_instr", wr_instr_q[i], w);
    end
    if (acc_cyc_q.size() == stream_q.size()) begin
      for (int i = 0; i < ne && i < wr_cyc_q.size(); i++)
        check("wr_latency", wr_cyc_q[i] - acc_cyc_q[2 + 4*i + 3], 2);
      for (int i = 0; i + 1 < n; i++)
        check("next_byte_gap", (acc_cyc_q[2 + 4*i + 4] - acc_cyc_q[2 + 4*i + 3]) >= 3, 1);
      last = acc_cyc_q[acc_cyc_q.size() - 1];
      check("rst_hold", fall_cyc - last, (n == 0) ? HOLD + 1 : HOLD + 3);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("r_rx_ready", rx_ready, 1);
    check("r_wr_en", dbg_wr_en, 0);
    check("r_addr", dbg_addr, 0);
    check("r_instr", dbg_instr, 0);
    check("r_core_rst", core_rst, 1);
    check("r_load_done", load_done, 0);
    check("r_load_err", load_err, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // single word
    stream_q = '{8'h01, 8'h00, 8'hB3, 8'h81, 8'h20, 8'h00};
    run_stream(1'b0, 1'b0);

    // four words back to back
    pulse_restart();
    new_stream(4);
    push_word(32'h002081B3);
    push_word(32'h00310093);
    push_word(32'h002081BB);
    push_word(32'h0031009B);
    run_stream(1'b0, 1'b0);

    // empty image, then bytes offered in DONE must be refused
    pulse_restart();
    new_stream(0);
    run_stream(1'b1, 1'b0);
    clear_log();
    rx_valid = 1'b1;
    rx_data  = 8'h5A;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("done_rx_ready", rx_ready, 0);
    end
    rx_valid = 1'b0;
    check("done_no_write", wr_addr_q.size(), 0);

    // reset in the middle of the second word
    pulse_restart();
    new_stream(3);
    push_word(32'hDEADBEEF);
    push_word(32'h12345678);
    for (int i = 0; i < 8; i++) send_byte(stream_q[i], 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("mr_rx_ready", rx_ready, 1);
    check("mr_wr_en", dbg_wr_en, 0);
    check("mr_addr", dbg_addr, 0);
    check("mr_instr", dbg_instr, 0);
    check("mr_core_rst", core_rst, 1);
    check("mr_load_done", load_done, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    new_stream(2);
    push_word($urandom);
    push_word($urandom);
    run_stream(1'b1, 1'b0);

    // more words than imem holds
    pulse_restart();
    new_stream(IMEMW + 2);
    for (int i = 0; i < IMEMW + 2; i++) push_word($urandom);
    run_stream(1'b1, 1'b0);

    // restart clears the error and reloads
    pulse_restart();
    stream_q = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
    run_stream(1'b0, 1'b0);

    // random images, with a stray restart pulse mid-load that must be ignored
    for (int r = 0; r < 5; r++) begin
      int n;
      pulse_restart();
      n = $urandom_range(1, IMEMW);
      new_stream(n);
      for (int i = 0; i < n; i++) push_word($urandom);
      run_stream(1'b1, r[0]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
